trap_controller: RTL and testbench

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller_pkg.sv | 51 +++++
 rtl/trap_controller.sv | 122 ++++++++++++
 tb/tb_trap_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_controller_pkg.sv
// Shared definitions for the machine-mode trap path: SYSTEM opcode fields,
// trap kinds, mcause codes, CSR addresses and the trap sequencer states.
package trap_controller_pkg;

  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  localparam logic [11:0] FUNCT12_ECALL  = 12'h000;
  localparam logic [11:0] FUNCT12_EBREAK = 12'h001;
  localparam logic [11:0] FUNCT12_MRET   = 12'h302;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  localparam logic [31:0] MCAUSE_ECALL_M          = 32'd11;
  localparam logic [31:0] MCAUSE_BREAKPOINT       = 32'd3;
  localparam logic [31:0] MCAUSE_INSTR_MISALIGNED = 32'd0;

  typedef enum logic [1:0] {
    TRAP_ECALL      = 2'b00,
    TRAP_EBREAK     = 2'b01,
    TRAP_MISALIGNED = 2'b10,
    TRAP_MRET       = 2'b11
  } trap_kind_e;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WRITE_MEPC   = 3'd1,
    WRITE_MCAUSE = 3'd2,
    READ_MTVEC   = 3'd3,
    READ_MEPC    = 3'd4,
    DEBUG        = 3'd5,
    GOTO         = 3'd6
  } trap_state_e;

  function automatic logic [31:0] mcause_code(input trap_kind_e kind);
    logic [31:0] code;
    code = MCAUSE_INSTR_MISALIGNED;
    case (kind)
      TRAP_ECALL:      code = MCAUSE_ECALL_M;
      TRAP_EBREAK:     code = MCAUSE_BREAKPOINT;
      TRAP_MISALIGNED: code = MCAUSE_INSTR_MISALIGNED;
      default:         code = MCAUSE_INSTR_MISALIGNED;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: saves mepc/mcause, fetches the handler or
// return address, and hands a one-cycle redirect to the PC controller.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [11:0] MTVEC_ADDR  = CSR_MTVEC,
  parameter logic [11:0] MEPC_ADDR   = CSR_MEPC,
  parameter logic [11:0] MCAUSE_ADDR = CSR_MCAUSE
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            trapped,
  input  logic [1:0]      trap_status,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] csr_read_data,
  input  logic            debug_resume,
  output logic            csr_write_enable,
  output logic [11:0]     csr_address,
  output logic [XLEN-1:0] csr_write_data,
  output logic [XLEN-1:0] trap_target,
  output logic            trap_done,
  output logic            pc_stall,
  output logic            debug_mode
);

  trap_state_e     state, state_next;
  trap_kind_e      kind_q, kind_next;
  logic [XLEN-1:0] pc_q, pc_next;
  logic [XLEN-1:0] target_q, target_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      kind_q   <= TRAP_ECALL;
      pc_q     <= '0;
      target_q <= '0;
    end else begin
      state    <= state_next;
      kind_q   <= kind_next;
      pc_q     <= pc_next;
      target_q <= target_next;
    end
  end

  // Only IDLE looks at trapped; every other state runs to completion.
  always_comb begin
    state_next       = state;
    kind_next        = kind_q;
    pc_next          = pc_q;
    target_next      = target_q;
    csr_write_enable = 1'b0;
    csr_address      = '0;
    csr_write_data   = '0;
    trap_target      = '0;
    trap_done        = 1'b0;
    pc_stall         = 1'b1;
    debug_mode       = 1'b0;

    case (state)
      IDLE: begin
        pc_stall = trapped;
        if (trapped) begin
          pc_next   = pc;
          kind_next = trap_kind_e'(trap_status);
          case (trap_kind_e'(trap_status))
            TRAP_EBREAK: state_next = DEBUG;
            TRAP_MRET:   state_next = READ_MEPC;
            default:     state_next = WRITE_MEPC;
          endcase
        end
      end

      WRITE_MEPC: begin
        csr_write_enable = 1'b1;
        csr_address      = MEPC_ADDR;
        csr_write_data   = pc_q;
        state_next       = WRITE_MCAUSE;
      end

      WRITE_MCAUSE: begin
        csr_write_enable = 1'b1;
        csr_address      = MCAUSE_ADDR;
        csr_write_data   = XLEN'(mcause_code(kind_q));
        state_next       = READ_MTVEC;
      end

      // Direct-mode vectoring: the mode bits of mtvec are not part of the address.
      READ_MTVEC: begin
        csr_address = MTVEC_ADDR;
        target_next = {csr_read_data[XLEN-1:2], 2'b00};
        state_next  = GOTO;
      end

      READ_MEPC: begin
        csr_address = MEPC_ADDR;
        target_next = csr_read_data;
        state_next  = GOTO;
      end

      DEBUG: begin
        debug_mode = 1'b1;
        if (debug_resume) begin
          target_next = pc_q + XLEN'(4);
          state_next  = GOTO;
        end
      end

      GOTO: begin
        trap_done   = 1'b1;
        trap_target = target_q;
        state_next  = IDLE;
      end

      default: begin
        pc_stall   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: each trap scenario queues its
// per-cycle inputs and expected outputs, which are replayed and compared.
module tb_trap_controller;
  import trap_controller_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        trapped;
  logic [1:0]  trap_status;
  logic [31:0] pc;
  logic [31:0] csr_read_data;
  logic        debug_resume;
  logic        csr_write_enable;
  logic [11:0] csr_address;
  logic [31:0] csr_write_data;
  logic [31:0] trap_target;
  logic        trap_done;
  logic        pc_stall;
  logic        debug_mode;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst_n;
    logic        trapped;
    logic [1:0]  status;
    logic [31:0] pc;
    logic        resume;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] target;
    logic        stall;
    logic        dbg;
  } cycle_t;

  cycle_t sb_q[$];
  int     cycle_no = 0;

  logic [31:0] env_mtvec, env_mepc, env_mcause;
  logic        tb_we;
  logic [11:0] tb_addr;
  logic [31:0] tb_data;

  trap_controller dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .trapped          (trapped),
    .trap_status      (trap_status),
    .pc               (pc),
    .csr_read_data    (csr_read_data),
    .debug_resume     (debug_resume),
    .csr_write_enable (csr_write_enable),
    .csr_address      (csr_address),
    .csr_write_data   (csr_write_data),
    .trap_target      (trap_target),
    .trap_done        (trap_done),
    .pc_stall         (pc_stall),
    .debug_mode       (debug_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal CSR file: the DUT writes take priority over bench preloads.
  always @(posedge clk) begin
    if (csr_write_enable) begin
      case (csr_address)
        12'h305: env_mtvec  <= csr_write_data;
        12'h341: env_mepc   <= csr_write_data;
        12'h342: env_mcause <= csr_write_data;
        default: ;
      endcase
    end else if (tb_we) begin
      case (tb_addr)
        12'h305: env_mtvec  <= tb_data;
        12'h341: env_mepc   <= tb_data;
        12'h342: env_mcause <= tb_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_read_data = 32'h0;
    case (csr_address)
      12'h305: csr_read_data = env_mtvec;
      12'h341: csr_read_data = env_mepc;
      12'h342: csr_read_data = env_mcause;
      default: csr_read_data = 32'h0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic pushCycle(input logic rst_n, input logic trp, input logic [1:0] st,
                           input logic [31:0] pcv, input logic res,
                           input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic done, input logic [31:0] target,
                           input logic stall, input logic dbg);
    cycle_t c;
    c.rst_n = rst_n; c.trapped = trp; c.status = st; c.pc = pcv; c.resume = res;
    c.we = we; c.addr = addr; c.wdata = wdata; c.done = done; c.target = target;
    c.stall = stall; c.dbg = dbg;
    sb_q.push_back(c);
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++)
      pushCycle(1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Expected trace of one complete trap sequence, starting with the IDLE request cycle.
  // The pc input is scrambled after the request so only the latched copy can be used.
  task automatic pushTrap(input logic [1:0] kind, input logic [31:0] pcv, input logic [31:0] csr_val,
                          input logic hold, input int debug_cycles);
    logic [31:0] other_pc;
    logic [31:0] cause;
    other_pc = ~pcv;
    cause    = (kind == 2'b00) ? 32'd11 : 32'd0;
    pushCycle(1'b1, 1'b1, kind, pcv, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    case (kind)
      2'b00, 2'b10: begin
        pushCycle(1'b1, hold, kind, other_pc, 1'b0, 1'b1, 12'h341, pcv,   1'b0, 32'h0, 1'b1, 1'b0);
        pushCycle(1'b1, hold, kind, other_pc, 1'b0, 1'b1, 12'h342, cause, 1'b0, 32'h0, 1'b1, 1'b0);
        pushCycle(1'b1, hold, kind, other_pc, 1'b0, 1'b0, 12'h305, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        pushCycle(1'b1, hold, kind, other_pc, 1'b0, 1'b0, 12'h0,   32'h0, 1'b1,
                  csr_val & 32'hFFFF_FFFC, 1'b1, 1'b0);
      end
      2'b11: begin
        pushCycle(1'b1, hold, kind, other_pc, 1'b0, 1'b0, 12'h341, 32'h0, 1'b0, 32'h0,   1'b1, 1'b0);
        pushCycle(1'b1, hold, kind, other_pc, 1'b0, 1'b0, 12'h0,   32'h0, 1'b1, csr_val, 1'b1, 1'b0);
      end
      default: begin
        for (int i = 0; i < debug_cycles; i++)
          pushCycle(1'b1, hold, kind, other_pc, (i == debug_cycles - 1), 1'b0, 12'h0, 32'h0,
                    1'b0, 32'h0, 1'b1, 1'b1);
        pushCycle(1'b1, hold, kind, other_pc, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, pcv + 32'd4, 1'b1, 1'b0);
      end
    endcase
  endtask

  task automatic applyStimulus(input cycle_t c);
    reset_n      = c.rst_n;
    trapped      = c.trapped;
    trap_status  = c.status;
    pc           = c.pc;
    debug_resume = c.resume;
  endtask

  // Drain the scoreboard: drive each cycle's inputs, then compare once outputs settle.
  task automatic runScoreboard();
    cycle_t c;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      @(negedge clk);
      applyStimulus(c);
      #1;
      checkOutput($sformatf("c%0d csr_write_enable", cycle_no), {31'b0, csr_write_enable}, {31'b0, c.we});
      checkOutput($sformatf("c%0d csr_address", cycle_no), {20'b0, csr_address}, {20'b0, c.addr});
      checkOutput($sformatf("c%0d csr_write_data", cycle_no), csr_write_data, c.wdata);
      checkOutput($sformatf("c%0d trap_done", cycle_no), {31'b0, trap_done}, {31'b0, c.done});
      checkOutput($sformatf("c%0d trap_target", cycle_no), trap_target, c.target);
      checkOutput($sformatf("c%0d pc_stall", cycle_no), {31'b0, pc_stall}, {31'b0, c.stall});
      checkOutput($sformatf("c%0d debug_mode", cycle_no), {31'b0, debug_mode}, {31'b0, c.dbg});
      cycle_no++;
    end
  endtask

  task automatic preloadCsr(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    tb_we   = 1'b1;
    tb_addr = addr;
    tb_data = data;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; trapped = 1'b0; trap_status = 2'b00; pc = 32'h0; debug_resume = 1'b0;
    tb_we = 1'b0; tb_addr = 12'h0; tb_data = 32'h0;
    repeat (2) @(posedge clk);
    preloadCsr(12'h305, 32'h0000_0200);
    preloadCsr(12'h341, 32'h0);
    preloadCsr(12'h342, 32'hDEAD_BEEF);

    $display("[TB] reset state and ECALL");
    pushIdle(2);
    pushTrap(2'b00, 32'h0000_0100, 32'h0000_0200, 1'b0, 0);
    pushIdle(1);
    runScoreboard();
    checkOutput("ecall mepc", env_mepc, 32'h0000_0100);
    checkOutput("ecall mcause", env_mcause, 32'd11);

    $display("[TB] misaligned with unaligned mtvec");
    preloadCsr(12'h305, 32'h0000_0203);
    pushTrap(2'b10, 32'h0000_00F0, 32'h0000_0203, 1'b0, 0);
    pushIdle(1);
    runScoreboard();
    checkOutput("misaligned mepc", env_mepc, 32'h0000_00F0);
    checkOutput("misaligned mcause", env_mcause, 32'd0);

    $display("[TB] MRET");
    preloadCsr(12'h341, 32'h0000_0104);
    pushTrap(2'b11, 32'h0000_0AAA, 32'h0000_0104, 1'b0, 0);
    pushIdle(1);
    runScoreboard();
    checkOutput("mret leaves mcause", env_mcause, 32'd0);

    $display("[TB] EBREAK with pc wrap");
    pushTrap(2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0, 5);
    pushIdle(1);
    runScoreboard();

    $display("[TB] trapped held for ten cycles");
    preloadCsr(12'h305, 32'h0000_0200);
    pushTrap(2'b00, 32'h0000_0100, 32'h0000_0200, 1'b1, 0);
    pushTrap(2'b00, 32'h0000_0100, 32'h0000_0200, 1'b1, 0);
    pushIdle(2);
    runScoreboard();

    $display("[TB] reset during WRITE_MCAUSE");
    pushCycle(1'b1, 1'b1, 2'b00, 32'h0000_0300, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    pushCycle(1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 12'h341, 32'h0000_0300, 1'b0, 32'h0, 1'b1, 1'b0);
    pushCycle(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 12'h342, 32'd11, 1'b0, 32'h0, 1'b1, 1'b0);
    pushIdle(4);
    runScoreboard();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
